sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares the single synchronous SRAM port between the instruction-fetch requester (IF) and the data-memory requester (MEM).
- Sits between InstructionMemory/DataMemory and the top-level sram_* pins.
- Issues at most one SRAM access per cycle. The read result returns one cycle after issue, with a per-requester ready pulse.
- Sustains one access per cycle when both requesters alternate.

Parameters:
- ADDR_MASK_BITS, 3: number of upper address bits forced to zero when forming sram_addr (kseg0/kseg1 unmapped translation).
- ADDR_W, 32: address and data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF access request; held until if_ready
- if_addr  in  32  IF byte address; stable while if_req
- if_rdata  out  32  IF read data; valid only when if_ready
- if_ready  out  1  one-cycle pulse: IF access complete
- mem_req  in  1  MEM access request; held until mem_ready
- mem_wen  in  4  byte write enables; 0 = read
- mem_addr  in  32  MEM byte address
- mem_wdata  in  32  MEM write data
- mem_rdata  out  32  MEM read data; valid only when mem_ready
- mem_ready  out  1  one-cycle pulse: MEM access complete
- sram_en  out  1  SRAM enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid one cycle after the address cycle

Behaviour:
- Reset (async, rst=1): owner register = NONE; if_ready=0, mem_ready=0; if_rdata=0, mem_rdata=0; sram_en=0, sram_wen=0.
- Owner register holds the requester issued last cycle: NONE, IF or MEM. It is updated every cycle to the current grant.
- Eligibility: a requester is eligible when req=1 AND it is not the current owner. The owner's ready fires this cycle and its req is still visible, so it must not be re-issued.
- Grant (combinational, fixed priority): MEM eligible → MEM; else IF eligible → IF; else NONE.
- SRAM drive in the grant cycle:
  - sram_en = (grant != NONE).
  - sram_wen = mem_wen when grant=MEM, else 0.
  - sram_addr = {ADDR_MASK_BITS zeros, addr[ADDR_W-1-ADDR_MASK_BITS:0]} of the granted requester.
  - sram_wdata = mem_wdata when grant=MEM, else 0.
- Ready generation (registered): if_ready = (owner==IF), mem_ready = (owner==MEM). Ready occurs exactly 1 cycle after grant.
- Read data: xx_rdata = sram_rdata when xx_ready, else 0. For writes, mem_rdata is don't-care but still driven as specified.
- Latency: 1 cycle, grant to ready. A single requester alone gets one access every 2 cycles. Both requesting continuously alternate MEM, IF, MEM, IF…
- No alignment checking. Misaligned addresses are passed through unchanged; exceptions are raised upstream.
- Reset asserted mid-access: the outstanding access is dropped and no ready is issued. A requester still holding req after reset is granted normally.
- Both req fall in the ready cycle: next grant = NONE and sram_en=0 in that cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-winner register (reset value IF) breaks ties when both are eligible. The requester that did not win last time is granted. The register updates on every non-NONE grant.
- Undefined: fixed MEM priority as above.
- Both modes are identical whenever only one requester is eligible.

Decomposition:
- Shared package holds:
  - owner encoding typedef: NONE=2'd0, IF=2'd1, MEM=2'd2
  - ADDR_W
  - kseg translation mask constant
- Sub-module arb_grant2: pure combinational 2-way grant, including the optional round-robin state input. Everything else stays in sram_arbiter.

Test Plan:
- Reset with if_req=1, if_addr=0xBFC00000 → after release: sram_en=1, sram_addr=0x1FC00000, wen=0. Next cycle if_ready=1 and if_rdata equals the SRAM model word.
- IF and MEM held continuously, mem_wen=0 → grants alternate MEM, IF, MEM. Each ready pulses every 2nd cycle, never both in the same cycle.
- MEM write: mem_wen=4'b0011, addr=0x80001004, wdata=0xDEADBEEF → sram_wen=0011 and sram_addr=0x00001004 in the grant cycle. mem_ready=1 next cycle; readback of 0x80001004 gives low half 0xBEEF.
- rst pulsed in the cycle after an IF grant → if_ready stays 0 and all outputs return to reset values asynchronously.
- ARB_ROUND_ROBIN_EN defined, IF and MEM rise in the same cycle after reset → IF is NOT granted first (last-winner=IF), so MEM first, then IF. Without the macro: MEM first as well. Repeat the test with MEM held alone for one access, then both rising together: IF must be granted first under round robin.
- Only IF requesting for 10 cycles → sram_en toggles 1,0,1,0… and if_ready lags each sram_en by exactly 1 cycle.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: owner encoding, address
// width and the kseg0/kseg1 unmapped-translation mask.
package sram_arbiter_pkg;

  localparam int unsigned SRAM_ADDR_W    = 32;
  localparam int unsigned KSEG_MASK_BITS = 3;

  // Requester that owns the SRAM access issued in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_t;

  // All-ones mask with the top 'bits' address bits cleared.
  function automatic logic [SRAM_ADDR_W-1:0] kseg_mask(input int unsigned bits);
    logic [SRAM_ADDR_W-1:0] m;
    m = '1;
    m = m >> bits;
    return m;
  endfunction

  localparam logic [SRAM_ADDR_W-1:0] KSEG_MASK = kseg_mask(KSEG_MASK_BITS);

endpackage

// File: rtl/arb_grant2.sv
// Combinational two-way grant between IF and MEM.
// ARB_ROUND_ROBIN_EN: when defined, a tie is broken in favour of the
// requester that did not win the previous non-NONE grant; otherwise MEM
// has fixed priority.
module arb_grant2
  import sram_arbiter_pkg::*;
(
  input  logic   if_elig,
  input  logic   mem_elig,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic   last_mem,   // 1: MEM won the last non-NONE grant
`endif
  output owner_t grant
);

  // Pick one eligible requester; only a tie depends on the arbitration mode.
  always_comb begin
    grant = OWN_NONE;
    if (mem_elig && if_elig) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = last_mem ? OWN_IF : OWN_MEM;
`else
      grant = OWN_MEM;
`endif
    end else if (mem_elig) begin
      grant = OWN_MEM;
    end else if (if_elig) begin
      grant = OWN_IF;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch (IF) and data
// memory (MEM). One access per cycle, ready one cycle after grant.
// ARB_ROUND_ROBIN_EN: when defined, ties alternate via a last-winner flop
// instead of fixed MEM priority.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_MASK_BITS = KSEG_MASK_BITS,
  parameter int unsigned ADDR_W         = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [ADDR_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [ADDR_W-1:0] sram_wdata,
  input  logic [ADDR_W-1:0] sram_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(kseg_mask(ADDR_MASK_BITS));

  owner_t owner_q, owner_d;
  owner_t grant;
  logic   if_elig, mem_elig;

  // The owner's ready fires this cycle while its req is still up, so it is
  // excluded; reset also blocks issue so the SRAM pins idle asynchronously.
  always_comb begin
    if_elig  = if_req  && (owner_q != OWN_IF)  && !rst;
    mem_elig = mem_req && (owner_q != OWN_MEM) && !rst;
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_mem_q, last_mem_d;

  // Remember the winner of every non-NONE grant for tie breaking.
  always_comb begin
    last_mem_d = last_mem_q;
    if (grant == OWN_MEM) last_mem_d = 1'b1;
    else if (grant == OWN_IF) last_mem_d = 1'b0;
  end

  // Last-winner register, reset to IF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_mem_q <= 1'b0;
    else     last_mem_q <= last_mem_d;
  end

  arb_grant2 u_grant (
    .if_elig  (if_elig),
    .mem_elig (mem_elig),
    .last_mem (last_mem_q),
    .grant    (grant)
  );
`else
  arb_grant2 u_grant (
    .if_elig  (if_elig),
    .mem_elig (mem_elig),
    .grant    (grant)
  );
`endif

  // Owner tracks the grant issued this cycle.
  always_comb begin
    owner_d = grant;
  end

  // Owner register; a reset mid-access drops the outstanding ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner_q <= OWN_NONE;
    else     owner_q <= owner_d;
  end

  // Drive the SRAM port from the granted requester.
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (grant)
      OWN_MEM: begin
        sram_en    = 1'b1;
        sram_wen   = mem_wen;
        sram_addr  = mem_addr & ADDR_MASK;
        sram_wdata = mem_wdata;
      end
      OWN_IF: begin
        sram_en    = 1'b1;
        sram_addr  = if_addr & ADDR_MASK;
      end
      default: ;
    endcase
  end

  // Ready pulses come from the owner flop; read data is gated by ready.
  always_comb begin
    if_ready  = (owner_q == OWN_IF);
    mem_ready = (owner_q == OWN_MEM);
    if_rdata  = if_ready  ? sram_rdata : '0;
    mem_rdata = mem_ready ? sram_rdata : '0;
  end

endmodule
